// File: rtl/sensor_node_pkg.sv
// -----------------------------------------------------------------------------
// sensor_node_pkg
// Shared definitions for the sensor node sequencer:
//   - state_t        : sequencer FSM states (CSUM only with SENSOR_NODE_CHECKSUM_EN)
//   - EN_*_OFS       : offsets of the radio/memory bits above the sensor bits
//                      in the power-enable vector
//   - DEF_*          : default parameter values for the sequencer
// Optional build macro: SENSOR_NODE_CHECKSUM_EN
// -----------------------------------------------------------------------------
package sensor_node_pkg;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_NUM_SENSORS    = 2;
  localparam int DEF_BATCH_LEN      = 16;
  localparam int DEF_SAMPLE_PERIOD  = 1000;
  localparam int DEF_SENSOR_TIMEOUT = 64;
  localparam int DEF_PMU_MIN        = 'h40;

  // enables layout: [NUM_SENSORS-1:0] sensors, then radio, then memory
  localparam int EN_RADIO_OFS = 0;
  localparam int EN_MEM_OFS   = 1;

  function automatic int en_radio_bit(input int num_sensors);
    return num_sensors + EN_RADIO_OFS;
  endfunction

  function automatic int en_mem_bit(input int num_sensors);
    return num_sensors + EN_MEM_OFS;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    STORE,
    CHECK,
    READ,
    SEND
`ifdef SENSOR_NODE_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

endpackage

// File: rtl/sensor_node_ring_ptr.sv
// -----------------------------------------------------------------------------
// sensor_node_ring_ptr
// Circular-buffer bookkeeping for a 2**ADDR_W deep sample store.
// A push into a full buffer overwrites the oldest entry: the read pointer is
// dragged along, the count stays at DEPTH and the sticky overflow flag sets.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push           a sample is written at o_wr_ptr this cycle
//   i_pop            the entry at o_rd_ptr is consumed this cycle
//   o_wr_ptr         next write address
//   o_rd_ptr         oldest stored entry
//   o_count          number of stored entries (0..DEPTH)
//   o_full, o_empty  count == DEPTH / count == 0
//   o_overflow       sticky: an overwrite has occurred since reset
// -----------------------------------------------------------------------------
module sensor_node_ring_ptr #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [ADDR_W-1:0] o_rd_ptr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_overwrite;

  assign w_full      = (r_count == DEPTH);
  assign w_empty     = (r_count == '0);
  // popping an empty buffer is ignored so the count can never underflow
  assign w_pop       = i_pop && !w_empty;
  assign w_overwrite = i_push && w_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop || w_overwrite) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !w_pop && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !i_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_overwrite) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_wr_ptr   = r_wr_ptr;
  assign o_rd_ptr   = r_rd_ptr;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/sensor_node_sequencer.sv
// -----------------------------------------------------------------------------
// sensor_node_sequencer
// Periodically samples NUM_SENSORS channels into a circular buffer held in an
// external synchronous memory, and bursts BATCH_LEN samples to the radio when
// enough data is buffered and the PMU reports sufficient supply.
// Optional build macro: SENSOR_NODE_CHECKSUM_EN -- appends an XOR checksum
// byte (state CSUM) after every burst.
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   enable            run enable for the sample timer
//   sensor_data       packed channel data, channel i at [i*DATA_W +: DATA_W]
//   sensor_valid      per-channel data valid
//   memory_data       memory read data, one cycle after memory_address
//   radio_ready       radio accepts the current byte
//   PMU_data          supply level, unsigned
//   write_to_memory   memory write strobe
//   memory_data_out   memory write data
//   memory_address    memory address
//   radio_Tx          radio byte valid
//   radio_data_out    radio byte
//   enables           power enables: sensors, radio, memory
//   overflow          sticky buffer-overwrite flag
//   busy              FSM not in IDLE
// -----------------------------------------------------------------------------
module sensor_node_sequencer
  import sensor_node_pkg::*;
#(
  parameter int                DATA_W         = DEF_DATA_W,
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter int                NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int                BATCH_LEN      = DEF_BATCH_LEN,
  parameter int                SAMPLE_PERIOD  = DEF_SAMPLE_PERIOD,
  parameter int                SENSOR_TIMEOUT = DEF_SENSOR_TIMEOUT,
  parameter logic [DATA_W-1:0] PMU_MIN        = DATA_W'(DEF_PMU_MIN)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
  input  logic [NUM_SENSORS-1:0]        sensor_valid,
  input  logic [DATA_W-1:0]             memory_data,
  input  logic                          radio_ready,
  input  logic [DATA_W-1:0]             PMU_data,
  output logic                          write_to_memory,
  output logic [DATA_W-1:0]             memory_data_out,
  output logic [ADDR_W-1:0]             memory_address,
  output logic                          radio_Tx,
  output logic [DATA_W-1:0]             radio_data_out,
  output logic [NUM_SENSORS+1:0]        enables,
  output logic                          overflow,
  output logic                          busy
);

  localparam int CNT_W    = ADDR_W + 1;
  localparam int CH_W     = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int TMR_W    = $clog2(SAMPLE_PERIOD);
  localparam int TO_W     = $clog2(SENSOR_TIMEOUT + 1);
  localparam int EN_RADIO = en_radio_bit(NUM_SENSORS);
  localparam int EN_MEM   = en_mem_bit(NUM_SENSORS);

  state_t             r_state;
  state_t             w_state_next;
  logic [TMR_W-1:0]   r_timer;
  logic [CH_W-1:0]    r_ch;
  logic [TO_W-1:0]    r_wait;
  logic [DATA_W-1:0]  r_sample;
  logic [CNT_W-1:0]   r_sent;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_tx_held;

  logic [DATA_W-1:0]  w_ch_data [NUM_SENSORS];
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_valid;
  logic               w_timeout;
  logic               w_tick;
  logic               w_last_ch;
  logic               w_last_byte;
  logic               w_batch_ok;
  logic [DATA_W-1:0]  w_tx_byte;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_wr_ptr;
  logic [ADDR_W-1:0]  w_rd_ptr;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_unused_full;

  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_ch
    assign w_ch_data[gi] = sensor_data[gi*DATA_W +: DATA_W];
  end

  assign w_sel_data    = w_ch_data[r_ch];
  assign w_sel_valid   = sensor_valid[r_ch];
  assign w_timeout     = (r_wait == TO_W'(SENSOR_TIMEOUT - 1));
  // The round starts on the edge where the count would reach SAMPLE_PERIOD-1,
  // so the timer reloads to 0 and never rests at that value.
  assign w_tick        = enable && (r_timer == TMR_W'(SAMPLE_PERIOD - 2));
  assign w_last_ch     = (r_ch == CH_W'(NUM_SENSORS - 1));
  assign w_last_byte   = (r_sent == CNT_W'(BATCH_LEN - 1));
  assign w_batch_ok    = (w_count >= CNT_W'(BATCH_LEN)) && (PMU_data >= PMU_MIN);
  // First SEND cycle uses the memory's registered read data directly; from
  // then on the captured copy holds the byte while the radio stalls.
  assign w_tx_byte     = r_tx_held ? r_tx_data : memory_data;
  assign busy          = (r_state != IDLE);
  assign w_unused_full = w_full;

  sensor_node_ring_ptr #(
    .ADDR_W (ADDR_W)
  ) u_ring (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (overflow)
  );

`ifdef SENSOR_NODE_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (r_state == CHECK) begin
      r_csum <= '0;
    end else if (r_state == SEND && radio_ready) begin
      r_csum <= r_csum ^ w_tx_byte;
    end
  end
`endif

  // Next state and all outputs; everything defaults to 0 so IDLE (and reset)
  // drives every output low.
  always_comb begin
    w_state_next    = r_state;
    write_to_memory = 1'b0;
    memory_data_out = '0;
    memory_address  = '0;
    radio_Tx        = 1'b0;
    radio_data_out  = '0;
    enables         = '0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        enables[r_ch]   = 1'b1;
        enables[EN_MEM] = 1'b1;
        if (w_sel_valid || w_timeout) begin
          w_state_next = STORE;
        end
      end
      STORE: begin
        enables[EN_MEM] = 1'b1;
        write_to_memory = 1'b1;
        memory_address  = w_wr_ptr;
        memory_data_out = r_sample;
        w_push          = 1'b1;
        w_state_next    = w_last_ch ? CHECK : SAMPLE;
      end
      CHECK: begin
        w_state_next = w_batch_ok ? READ : IDLE;
      end
      READ: begin
        enables[EN_MEM]   = 1'b1;
        enables[EN_RADIO] = 1'b1;
        memory_address    = w_rd_ptr;
        w_state_next      = SEND;
      end
      SEND: begin
        // address stays on rd_ptr so the memory output is not disturbed
        enables[EN_MEM]   = 1'b1;
        enables[EN_RADIO] = 1'b1;
        memory_address    = w_rd_ptr;
        radio_Tx          = 1'b1;
        radio_data_out    = w_tx_byte;
        if (radio_ready) begin
          w_pop = 1'b1;
`ifdef SENSOR_NODE_CHECKSUM_EN
          w_state_next = w_last_byte ? CSUM : READ;
`else
          w_state_next = w_last_byte ? IDLE : READ;
`endif
        end
      end
`ifdef SENSOR_NODE_CHECKSUM_EN
      CSUM: begin
        enables[EN_RADIO] = 1'b1;
        radio_Tx          = 1'b1;
        radio_data_out    = r_csum;
        if (radio_ready) begin
          w_state_next = IDLE;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_ch      <= '0;
      r_wait    <= '0;
      r_sample  <= '0;
      r_sent    <= '0;
      r_tx_data <= '0;
      r_tx_held <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_timer <= w_tick ? '0 : r_timer + 1'b1;
          end
          if (w_tick) begin
            r_ch   <= '0;
            r_wait <= '0;
          end
        end
        SAMPLE: begin
          if (w_sel_valid) begin
            r_sample <= w_sel_data;
          end else if (w_timeout) begin
            r_sample <= '1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        STORE: begin
          r_wait <= '0;
          if (!w_last_ch) begin
            r_ch <= r_ch + 1'b1;
          end
        end
        CHECK: begin
          if (w_batch_ok) begin
            r_sent <= '0;
          end
        end
        SEND: begin
          r_tx_data <= w_tx_byte;
          r_tx_held <= !radio_ready;
          if (radio_ready) begin
            r_sent <= r_sent + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_node_sequencer.sv
module tb_sensor_node_sequencer;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NS = 2;
  localparam int BL = 4;
  localparam int SP = 10;
  localparam int TO = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [NS*DW-1:0] sensor_data = {8'h22, 8'h11};
  logic [NS-1:0]    sensor_valid = 2'b11;
  logic [DW-1:0]    memory_data = '0;
  logic             radio_ready = 1'b1;
  logic [DW-1:0]    PMU_data = 8'h80;
  logic             write_to_memory;
  logic [DW-1:0]    memory_data_out;
  logic [AW-1:0]    memory_address;
  logic             radio_Tx;
  logic [DW-1:0]    radio_data_out;
  logic [NS+1:0]    enables;
  logic             overflow;
  logic             busy;

  sensor_node_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_SENSORS(NS), .BATCH_LEN(BL),
    .SAMPLE_PERIOD(SP), .SENSOR_TIMEOUT(TO), .PMU_MIN(8'h40)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .memory_data(memory_data), .radio_ready(radio_ready), .PMU_data(PMU_data),
    .write_to_memory(write_to_memory), .memory_data_out(memory_data_out),
    .memory_address(memory_address), .radio_Tx(radio_Tx),
    .radio_data_out(radio_data_out), .enables(enables),
    .overflow(overflow), .busy(busy)
  );

  always #5 clock = ~clock;

  // synchronous external memory: one-cycle read latency
  logic [DW-1:0] mem [1<<AW];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge clock) begin
    if (write_to_memory) mem[memory_address] <= memory_data_out;
    memory_data <= mem[memory_address];
  end

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_tx[$];
  int            tx_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  wr_t           mon_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // monitor: compares every memory write and every radio byte to the queues
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (write_to_memory) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", memory_address, memory_data_out);
        end else begin
          mon_e = exp_wr.pop_front();
          $display("wr  addr=%0h data=%0h", memory_address, memory_data_out);
          check("mem_write", {21'd0, memory_address, memory_data_out}, {21'd0, mon_e.addr, mon_e.data});
        end
      end
      if (radio_Tx) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tx actual=%0h required=none", radio_data_out);
        end else begin
          check("radio_byte", {24'd0, radio_data_out}, {24'd0, exp_tx[0]});
          if (radio_ready) begin
            void'(exp_tx.pop_front());
            tx_cyc.push_back(cyc);
            $display("tx  data=%0h", radio_data_out);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    exp_wr.delete();
    exp_tx.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    exp_wr.push_back({a, d0});
    exp_wr.push_back({AW'(a + 1), d1});
  endtask

  task automatic push_burst(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                            input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    exp_tx.push_back(b0); exp_tx.push_back(b1);
    exp_tx.push_back(b2); exp_tx.push_back(b3);
`ifdef SENSOR_NODE_CHECKSUM_EN
    exp_tx.push_back(b0 ^ b1 ^ b2 ^ b3);
`endif
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(exp_wr.size() == 0 && exp_tx.size() == 0 && !busy) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout actual=%0d required=<%0d", name, n, budget);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---- reset state
    do_reset();
    check("reset_outputs", {write_to_memory, memory_address, memory_data_out, radio_Tx, radio_data_out},
          32'd0);
    check("reset_enables", {28'd0, enables}, 32'd0);
    check("reset_flags", {30'd0, overflow, busy}, 32'd0);

    // ---- S1: two rounds, burst 11,22,11,22 with radio_ready high
    push_wr(3'd0, 8'h11, 8'h22);
    enable = 1'b1;
    n = 0;
    while (!write_to_memory && n < 50) begin step(); n++; end
    check("first_write_latency", n, 32'd10);
    wait_drain("s1_round1", 300);
    tx_cyc.delete();
    push_wr(3'd2, 8'h11, 8'h22);
    push_burst(8'h11, 8'h22, 8'h11, 8'h22);
    wait_drain("s1_round2", 300);
    enable = 1'b0;
    check("s1_tx_count", tx_cyc.size() >= BL, 32'd1);
    if (tx_cyc.size() >= BL)
      for (int i = 0; i < BL - 1; i++) check("s1_tx_spacing", tx_cyc[i+1] - tx_cyc[i], 32'd2);
    check("s1_count_after", {28'd0, dut.w_count}, 32'd0);

    // ---- S2: radio stalls 5 cycles mid-burst
    do_reset();
    push_wr(3'd0, 8'h11, 8'h22);
    enable = 1'b1;
    wait_drain("s2_round1", 300);
    tx_cyc.delete();
    push_wr(3'd2, 8'h11, 8'h22);
    push_burst(8'h11, 8'h22, 8'h11, 8'h22);
    n = 0;
    while (tx_cyc.size() < 2 && n < 300) begin step(); n++; end
    check("s2_reach_stall", n < 300, 32'd1);
    radio_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s2_tx_held", {31'd0, radio_Tx}, 32'd1);
    end
    radio_ready = 1'b1;
    wait_drain("s2_round2", 300);
    enable = 1'b0;
    check("s2_count_after", {28'd0, dut.w_count}, 32'd0);

    // ---- S3: PMU low defers the burst until supply recovers
    do_reset();
    PMU_data = 8'h20;
    enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_wr(AW'(2*r), 8'h11, 8'h22);
      wait_drain("s3_round", 300);
    end
    check("s3_count_grown", {28'd0, dut.w_count}, 32'd6);
    PMU_data = 8'h80;
    push_wr(3'd6, 8'h11, 8'h22);
    push_burst(8'h11, 8'h22, 8'h11, 8'h22);
    wait_drain("s3_burst", 300);
    enable = 1'b0;
    check("s3_count_after", {28'd0, dut.w_count}, 32'd4);

    // ---- S4: overflow with DEPTH=8, distinct sample values 1..12
    do_reset();
    PMU_data = 8'h20;
    enable = 1'b1;
    for (int r = 0; r < 5; r++) begin
      sensor_data = {8'(2*r + 2), 8'(2*r + 1)};
      push_wr(AW'(2*r), 8'(2*r + 1), 8'(2*r + 2));
      wait_drain("s4_round", 300);
      if (r == 3) check("s4_no_overflow_at_full", {31'd0, overflow}, 32'd0);
    end
    check("s4_overflow", {31'd0, overflow}, 32'd1);
    check("s4_rd_ptr", {29'd0, dut.w_rd_ptr}, 32'd2);
    check("s4_count", {28'd0, dut.w_count}, 32'd8);
    PMU_data = 8'h80;
    sensor_data = {8'd12, 8'd11};
    push_wr(3'd2, 8'd11, 8'd12);
    push_burst(8'd5, 8'd6, 8'd7, 8'd8);
    wait_drain("s4_burst", 300);
    enable = 1'b0;
    check("s4_rd_ptr_after", {29'd0, dut.w_rd_ptr}, 32'd0);
    check("s4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // ---- S5: channel 1 never valid -> all-ones marker
    do_reset();
    PMU_data = 8'h20;
    sensor_data = {8'h22, 8'h11};
    sensor_valid = 2'b01;
    push_wr(3'd0, 8'h11, 8'hFF);
    enable = 1'b1;
    n = 0;
    while (!write_to_memory && n < 50) begin step(); n++; end
    step();
    check("s5_enables_ch1", {28'd0, enables}, 32'b1010);
    wait_drain("s5_round", 300);
    enable = 1'b0;
    sensor_valid = 2'b11;

    // ---- S6: asynchronous reset in the middle of SEND
    do_reset();
    PMU_data = 8'h80;
    push_wr(3'd0, 8'h11, 8'h22);
    enable = 1'b1;
    wait_drain("s6_round1", 300);
    push_wr(3'd2, 8'h11, 8'h22);
    push_burst(8'h11, 8'h22, 8'h11, 8'h22);
    n = 0;
    while (!radio_Tx && n < 300) begin step(); n++; end
    check("s6_reach_send", {31'd0, radio_Tx}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("s6_async_outputs", {write_to_memory, memory_address, memory_data_out, radio_Tx, radio_data_out},
          32'd0);
    check("s6_async_flags", {26'd0, enables, overflow, busy}, 32'd0);
    exp_wr.delete();
    exp_tx.delete();
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("s6_after_release", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
